iter_divider: RTL

//  Iterative radix-2 restoring divider. It is the responder end of the dividend/divisor

---
 rtl/iter_divider_pkg.sv | 19 +
 rtl/iter_divider_if.sv | 47 ++++
 rtl/iter_divider_div_step.sv | 30 +++
 rtl/iter_divider.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
// -----------------------------------------------------------------------------
// iter_divider_pkg
// Shared definitions for the iterative radix-2 restoring divider:
//   - DIV_WIDTH_DEFAULT : default operand width
//   - div_state_t       : FSM state vector type
//   - DIV_IDLE/BUSY/DONE: FSM state encodings
// No ports (package).
// -----------------------------------------------------------------------------
package iter_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_BUSY = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

endpackage

// File: rtl/iter_divider_if.sv
// -----------------------------------------------------------------------------
// iter_divider_if
// Operand / result handshake bundle between the EX stage and iter_divider.
//   s_axis_dividend_tdata/tvalid/tready : dividend channel
//   s_axis_divisor_tdata/tvalid/tready  : divisor channel
//   m_axis_dout_tdata                   : {quotient, remainder}
//   m_axis_dout_tvalid                  : one-cycle result pulse (no tready)
// Modports: master = EX stage side, slave = divider side.
// -----------------------------------------------------------------------------
interface iter_divider_if
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;

  modport master (
    output s_axis_dividend_tdata,
    output s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_divisor_tdata,
    output s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    input  m_axis_dout_tdata,
    input  m_axis_dout_tvalid
  );

  modport slave (
    input  s_axis_dividend_tdata,
    input  s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_divisor_tdata,
    input  s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    output m_axis_dout_tdata,
    output m_axis_dout_tvalid
  );

endinterface

// File: rtl/iter_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step (one quotient bit).
//   rem_i     : current partial remainder (always < divisor_i when divisor_i != 0)
//   dvd_bit_i : next dividend bit, MSB first
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   qbit_o    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  // The shifted remainder needs WIDTH+1 bits for the compare; the subtraction
  // result always fits WIDTH bits when taken, so it is done modulo 2^WIDTH.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem_i, dvd_bit_i};
  assign diff    = shifted[WIDTH-1:0] - divisor_i;
  assign qbit_o  = (shifted >= {1'b0, divisor_i});
  assign rem_o   = qbit_o ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
// Iterative radix-2 restoring divider, responder end of the EX-stage
// dividend/divisor handshake. Accepts one operand pair, produces
// {quotient, remainder} after WIDTH iteration cycles and signals it with a
// one-cycle m_axis_dout_tvalid pulse. Initiation interval is WIDTH+2 cycles.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : iter_divider_if.slave (operand channels + result)
// Parameters:
//   WIDTH  : operand width
//   SIGNED : 1 = two's-complement divide, 0 = unsigned divide
// -----------------------------------------------------------------------------
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH_DEFAULT,
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  iter_divider_if.slave bus
);

  localparam int               CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dvd_got_q, dvd_got_d;
  logic               dsr_got_q, dsr_got_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;

  // dvd_q holds the dividend magnitude; it shifts left each step and the
  // quotient bits fill in from the bottom, so at the end it is the quotient.
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;

  logic               dvd_rdy, dsr_rdy;
  logic               dvd_fire, dsr_fire;
  logic [WIDTH-1:0]   step_rem;
  logic               step_qbit;
  logic [WIDTH-1:0]   q_final;
  logic               q_neg;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    if (SIGNED && (sv < 0)) return unsigned'(-sv);
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    return neg ? unsigned'(-sv) : v;
  endfunction

  assign dvd_rdy  = resetn && (state_q == DIV_IDLE) && !dvd_got_q;
  assign dsr_rdy  = resetn && (state_q == DIV_IDLE) && !dsr_got_q;
  assign dvd_fire = bus.s_axis_dividend_tvalid && dvd_rdy;
  assign dsr_fire = bus.s_axis_divisor_tvalid && dsr_rdy;

  assign bus.s_axis_dividend_tready = dvd_rdy;
  assign bus.s_axis_divisor_tready  = dsr_rdy;
  assign bus.m_axis_dout_tdata      = dout_q;
  assign bus.m_axis_dout_tvalid     = (state_q == DIV_DONE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  assign q_final = {dvd_q[WIDTH-2:0], step_qbit};
  // A zero divisor leaves the all-ones quotient unsigned; the remainder then
  // equals |a| and its sign fix restores the original dividend.
  assign q_neg   = (a_neg_q ^ b_neg_q) && (dsr_q != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_got_d = dvd_got_q;
    dsr_got_d = dsr_got_q;
    dout_d    = dout_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;

    case (state_q)
      DIV_IDLE: begin
        if (dvd_fire) begin
          dvd_got_d = 1'b1;
          dvd_d     = magnitude(bus.s_axis_dividend_tdata);
          a_neg_d   = SIGNED && bus.s_axis_dividend_tdata[WIDTH-1];
        end
        if (dsr_fire) begin
          dsr_got_d = 1'b1;
          dsr_d     = magnitude(bus.s_axis_divisor_tdata);
          b_neg_d   = SIGNED && bus.s_axis_divisor_tdata[WIDTH-1];
        end
        if ((dvd_got_q || dvd_fire) && (dsr_got_q || dsr_fire)) begin
          state_d   = DIV_BUSY;
          dvd_got_d = 1'b0;
          dsr_got_d = 1'b0;
          cnt_d     = '0;
          rem_d     = '0;
        end
      end
      DIV_BUSY: begin
        rem_d = step_rem;
        dvd_d = q_final;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DIV_DONE;
          dout_d  = {apply_sign(q_final, q_neg), apply_sign(step_rem, a_neg_q)};
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      dvd_got_q <= 1'b0;
      dsr_got_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_got_q <= dvd_got_d;
      dsr_got_q <= dsr_got_d;
      dout_q    <= dout_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    dvd_q   <= dvd_d;
    dsr_q   <= dsr_d;
    rem_q   <= rem_d;
    a_neg_q <= a_neg_d;
    b_neg_q <= b_neg_d;
  end

endmodule
